// File: rtl/locked_reg_write_ctrl_if.sv
// locked_reg_write_ctrl_if
//   Request/response handshake bundle for locked_reg_write_ctrl.
//   Request channel : req_valid, req_ready, req_data, req_lock
//   Response channel: rsp_valid, rsp_ready, rsp_err
//   master modport  : the requester (drives requests, accepts responses)
//   slave modport   : the controller (accepts requests, drives responses)
interface locked_reg_write_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic              req_lock;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_data,
        output req_lock,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_lock,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_err
    );
endinterface

// File: rtl/locked_reg_write_ctrl.sv
// locked_reg_write_ctrl
//   Write-request front end for a lockable configuration register. Accepts write and
//   lock commands, holds the sticky lock bit, refuses writes while scan is active or
//   while locked (unless debug_unlocked), and drives a one-cycle write strobe downstream.
//   Every request is answered with a response carrying an error flag.
//
// Ports
//   Clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   bus            request/response handshake (locked_reg_write_ctrl_if.slave)
//   scan_mode      scan active: all writes refused
//   debug_unlocked debug override: writes permitted while locked
//   wr_en, wr_data single-cycle write strobe and data to the register stage
//   lock_status    sticky lock bit, cleared only by reset
//   viol_cnt       saturating count of refused writes
//
// Configuration
//   LOCKED_REG_VIOL_CNT_EN: when defined, the violation counter is built; otherwise
//   viol_cnt is tied to zero and no counter flops exist.
module locked_reg_write_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   Clk,
    input  logic                   resetn,
    locked_reg_write_ctrl_if.slave bus,
    input  logic                   scan_mode,
    input  logic                   debug_unlocked,
    output logic                   wr_en,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   lock_status,
    output logic [CNT_W-1:0]       viol_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWrite,
        StDeny,
        StResp
    } state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] data_q;
    logic              lock_cmd_q;
    logic              lock_q;

    // All outputs come straight from flops. req_ready_q resets low and rises on the
    // first clock edge after reset release, so no request is taken while in reset.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            lock_cmd_q  <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_ready_q && bus.req_valid) begin
                        data_q      <= bus.req_data;
                        lock_cmd_q  <= bus.req_lock;
                        req_ready_q <= 1'b0;
                        state_q     <= StCheck;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StCheck: begin
                    // The decision is taken here once; later scan/debug changes cannot
                    // affect this request.
                    if (lock_cmd_q) begin
                        state_q <= StWrite;
                    end else if (scan_mode) begin
                        state_q <= StDeny;
                    end else if (lock_q && !debug_unlocked) begin
                        state_q <= StDeny;
                    end else begin
                        wr_en_q <= 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    // Lock commands never strobe the register; they only set the lock.
                    if (lock_cmd_q) begin
                        lock_q <= 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    state_q     <= StResp;
                end
                StDeny: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef LOCKED_REG_VIOL_CNT_EN
    logic [CNT_W-1:0] viol_cnt_q;

    // Counts once per DENY cycle and sticks at all-ones.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            viol_cnt_q <= '0;
        end else if (state_q == StDeny && viol_cnt_q != {CNT_W{1'b1}}) begin
            viol_cnt_q <= viol_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign viol_cnt = viol_cnt_q;
`else
    assign viol_cnt = '0;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign wr_en         = wr_en_q;
    assign wr_data       = data_q;
    assign lock_status   = lock_q;

endmodule

// File: tb/tb_locked_reg_write_ctrl.sv
// tb_locked_reg_write_ctrl
//   Self-checking bench for locked_reg_write_ctrl: directed scenarios followed by random
//   requests, compared against a transaction-level reference model. A narrow counter
//   (CNT_W = 2) makes saturation reachable quickly.
`timescale 1ns/1ps
module tb_locked_reg_write_ctrl;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              Clk = 1'b0;
    logic              resetn = 1'b0;
    logic              scan_mode = 1'b0;
    logic              debug_unlocked = 1'b0;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              lock_status;
    logic [CNT_W-1:0]  viol_cnt;

    locked_reg_write_ctrl_if #(.DATA_W(DATA_W)) bus ();

    locked_reg_write_ctrl #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk           (Clk),
        .resetn        (resetn),
        .bus           (bus),
        .scan_mode     (scan_mode),
        .debug_unlocked(debug_unlocked),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .lock_status   (lock_status),
        .viol_cnt      (viol_cnt)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lock bit, refused-write tally, last captured data.
    bit                m_locked = 1'b0;
    int                m_cnt = 0;
    logic [DATA_W-1:0] m_last = '0;

    // Throughput tracking between back-to-back requests.
    bit  rate_ok = 1'b0;
    time last_hs = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef LOCKED_REG_VIOL_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_req_ready"}, bus.req_ready, 0);
        check_val({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check_val({tag, "_rsp_err"}, bus.rsp_err, 0);
        check_val({tag, "_wr_en"}, wr_en, 0);
        check_val({tag, "_wr_data"}, wr_data, 0);
        check_val({tag, "_lock"}, lock_status, 0);
        check_val({tag, "_viol_cnt"}, viol_cnt, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
        rate_ok = 1'b0;
    endtask

    // One full transaction; called and returns on a falling edge.
    task automatic do_req(input bit lock, input logic [DATA_W-1:0] data, input bit scan,
                          input bit dbg, input int delay, input bit rst_in_resp);
        bit  exp_err;
        bit  exp_wr;
        int  w;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(negedge Clk);
            w++;
            rate_ok = 1'b0;
        end
        if (bus.req_ready !== 1'b1) begin
            check_val("ready_timeout", bus.req_ready, 1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_data   = data;
        bus.req_lock   = lock;
        scan_mode      = scan;
        debug_unlocked = dbg;
        @(posedge Clk);
        if (rate_ok) check_val("throughput_cycles", ($time - last_hs) / 10, 4);
        last_hs = $time;

        exp_err = !lock && (scan || (m_locked && !dbg));
        exp_wr  = !lock && !exp_err;
        m_last  = data;

        // CHECK cycle: scan/debug still held for sampling; request inputs scrambled.
        @(negedge Clk);
        bus.req_valid = 1'b0;
        bus.req_data  = DATA_W'($urandom);
        bus.req_lock  = 1'($urandom);
        check_val("check_wr_en", wr_en, 0);
        check_val("check_req_ready", bus.req_ready, 0);

        // WRITE/DENY cycle: scan/debug changes here must not matter.
        @(negedge Clk);
        scan_mode      = 1'($urandom);
        debug_unlocked = 1'($urandom);
        check_val("wr_en", wr_en, exp_wr);
        check_val("wr_data", wr_data, m_last);
        check_val("early_rsp_valid", bus.rsp_valid, 0);
        if (lock) m_locked = 1'b1;
        if (exp_err && m_cnt < CNT_MAX) m_cnt++;

        // First RESP cycle.
        @(negedge Clk);
        check_val("rsp_valid", bus.rsp_valid, 1);
        check_val("rsp_err", bus.rsp_err, exp_err);
        check_val("lock_status", lock_status, m_locked);
        check_val("viol_cnt", viol_cnt, exp_cnt());
        check_val("resp_wr_en", wr_en, 0);
        for (int i = 0; i < delay; i++) begin
            @(negedge Clk);
            check_val("hold_rsp_valid", bus.rsp_valid, 1);
            check_val("hold_rsp_err", bus.rsp_err, exp_err);
            check_val("hold_req_ready", bus.req_ready, 0);
            check_val("hold_wr_en", wr_en, 0);
        end

        if (rst_in_resp) begin
            resetn = 1'b0;
            #1;
            check_all_zero("mid_reset");
            m_locked = 1'b0;
            m_cnt    = 0;
            m_last   = '0;
            rate_ok  = 1'b0;
            @(negedge Clk);
            resetn = 1'b1;
            @(negedge Clk);
            check_val("post_reset_ready", bus.req_ready, 1);
            check_val("post_reset_wr_en", wr_en, 0);
            check_val("post_reset_lock", lock_status, 0);
            return;
        end

        bus.rsp_ready = 1'b1;
        @(negedge Clk);
        bus.rsp_ready = 1'b0;
        check_val("done_rsp_valid", bus.rsp_valid, 0);
        check_val("done_req_ready", bus.req_ready, 1);
        check_val("done_wr_data", wr_data, m_last);
        rate_ok = (delay == 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_lock  = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge Clk);
        check_all_zero("in_reset");
        resetn = 1'b1;
        @(negedge Clk);
        check_val("first_ready", bus.req_ready, 1);
        check_val("first_rsp_valid", bus.rsp_valid, 0);

        // Plain write, then lock, then refused write, then debug override.
        do_req(1'b0, 16'hA5A5, 1'b0, 1'b0, 0, 1'b0);
        do_req(1'b1, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        do_req(1'b0, 16'h1234, 1'b0, 1'b0, 0, 1'b0);
        do_req(1'b0, 16'hBEEF, 1'b0, 1'b1, 0, 1'b0);
        // Four more refused writes: counter saturates.
        for (int i = 0; i < 4; i++) do_req(1'b0, 16'(16'h1000 + i), 1'b0, 1'b0, 0, 1'b0);
        // Response held for 5 cycles, then reset mid-RESP while locked.
        do_req(1'b0, 16'h5555, 1'b0, 1'b0, 5, 1'b1);
        // Unlocked, scan active: refused even with debug override.
        do_req(1'b0, 16'h0F0F, 1'b1, 1'b1, 0, 1'b0);
        do_req(1'b0, 16'h0F0F, 1'b0, 1'b0, 2, 1'b0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            bit lk;
            bit sc;
            bit db;
            int dly;
            bit rst;
            lk  = ($urandom_range(0, 15) == 0);
            sc  = ($urandom_range(0, 3) == 0);
            db  = 1'($urandom);
            dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            do_req(lk, DATA_W'($urandom), sc, db, dly, rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule
